// File: rtl/dfr_batch_scheduler.sv
// Batch engine that walks a block of I/Q samples through the dfr_internal core.
// Define DFR_SCHED_TIMEOUT_EN to enable the per-sample watchdog (sched_error).
module dfr_batch_scheduler #(
  parameter int ADDR_W         = 12,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W:0]   cfg_num_samples,
  output logic [ADDR_W-1:0] in_ram_addr,
  input  logic [31:0]       in_ram_rdata,
  output logic              dfr_resetn,
  output logic              dfr_start,
  input  logic              dfr_busy,
  input  logic              dfr_done,
  output logic [15:0]       dfr_i_data,
  output logic [15:0]       dfr_q_data,
  input  logic [25:0]       dfr_returndata,
  output logic              out_ram_wen,
  output logic [ADDR_W-1:0] out_ram_addr,
  output logic [31:0]       out_ram_wdata,
  output logic              sched_busy,
  output logic              sched_done,
  output logic [ADDR_W:0]   sched_count,
  output logic              sched_error
);

  typedef enum logic [2:0] {
    IDLE, CORE_RST, FETCH, WAIT_RD, LAUNCH, WAIT_DONE, WRITE, FINISH
  } state_t;

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  state_t            state;
  logic [ADDR_W:0]   num;
  logic [ADDR_W-1:0] idx;
  logic [RC_W-1:0]   rst_cnt;
  logic [ADDR_W:0]   next_count;
  logic              to_hit;

  assign next_count   = sched_count + 1'b1;
  assign in_ram_addr  = idx;
  assign out_ram_addr = idx;
  assign sched_busy   = (state != IDLE);

`ifdef DFR_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state == LAUNCH || state == WAIT_DONE) &&
                  (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      to_cnt      <= '0;
      sched_error <= 1'b0;
    end else begin
      // Cleared on the edge that enters LAUNCH and the edge that enters WAIT_DONE.
      if (state == WAIT_RD || (state == LAUNCH && !dfr_busy))
        to_cnt <= '0;
      else if (state == LAUNCH || state == WAIT_DONE)
        to_cnt <= to_cnt + 1'b1;
      if (state == IDLE && cfg_start && !cfg_abort)
        sched_error <= 1'b0;
      else if (to_hit)
        sched_error <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign sched_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      num           <= '0;
      idx           <= '0;
      rst_cnt       <= '0;
      sched_count   <= '0;
      sched_done    <= 1'b0;
      dfr_resetn    <= 1'b1;
      dfr_start     <= 1'b0;
      dfr_i_data    <= '0;
      dfr_q_data    <= '0;
      out_ram_wen   <= 1'b0;
      out_ram_wdata <= '0;
    end else begin
      dfr_start   <= 1'b0;
      out_ram_wen <= 1'b0;
      sched_done  <= 1'b0;
      dfr_resetn  <= 1'b1;
      if (state != IDLE && (cfg_abort || to_hit)) begin
        // Abandon: one low cycle on the core reset flushes any in-flight sample.
        state      <= IDLE;
        dfr_resetn <= 1'b0;
        sched_done <= to_hit;
      end else begin
        case (state)
          IDLE: if (cfg_start && !cfg_abort) begin
            sched_count <= '0;
            idx         <= '0;
            if (cfg_num_samples == '0) begin
              sched_done <= 1'b1;
            end else begin
              num        <= cfg_num_samples;
              rst_cnt    <= '0;
              dfr_resetn <= 1'b0;
              state      <= CORE_RST;
            end
          end
          CORE_RST: begin
            if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
              state <= FETCH;
            end else begin
              rst_cnt    <= rst_cnt + 1'b1;
              dfr_resetn <= 1'b0;
            end
          end
          FETCH: state <= WAIT_RD;
          WAIT_RD: begin
            dfr_i_data <= in_ram_rdata[15:0];
            dfr_q_data <= in_ram_rdata[31:16];
            state      <= LAUNCH;
          end
          LAUNCH: if (!dfr_busy) begin
            dfr_start <= 1'b1;
            state     <= WAIT_DONE;
          end
          // A done seen while our own start is still high belongs to a previous job.
          WAIT_DONE: if (dfr_done && !dfr_start) begin
            out_ram_wdata <= {{6{dfr_returndata[25]}}, dfr_returndata};
            out_ram_wen   <= 1'b1;
            state         <= WRITE;
          end
          WRITE: begin
            sched_count <= next_count;
            idx         <= idx + 1'b1;
            if (next_count == num) begin
              sched_done <= 1'b1;
              state      <= FINISH;
            end else begin
              state <= FETCH;
            end
          end
          FINISH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dfr_batch_scheduler.md
Name: dfr_batch_scheduler

Overview:
Sequences the dfr_internal core over a buffered block of I/Q samples. Fetches each sample from an input sample RAM, launches the core with a start/busy/done handshake, and writes each 26-bit result to an output RAM. Sits between the host-facing register block and dfr_internal. Supersedes the single-sample dfr_fsm flow with an address-driven batch engine.

Parameters:
ADDR_W, 12, sample/result RAM address width (max batch 2^ADDR_W)
RST_CYCLES, 4, cycles dfr_resetn is held low before a batch
TIMEOUT_CYCLES, 1024, watchdog limit per sample (only with DFR_SCHED_TIMEOUT_EN)

Ports:
clock  in  1  system clock, all logic rising-edge
resetn  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse, begin batch (honoured only in IDLE)
cfg_abort  in  1  one-cycle pulse, abandon batch from any state
cfg_num_samples  in  ADDR_W+1  samples in batch, latched at cfg_start
in_ram_addr  out  ADDR_W  input RAM read address
in_ram_rdata  in  32  sample word: [15:0]=I, [31:16]=Q; valid 1 cycle after address
dfr_resetn  out  1  core reset, active-low
dfr_start  out  1  core start pulse
dfr_busy  in  1  core busy
dfr_done  in  1  core done pulse, result valid same cycle
dfr_i_data  out  16  I sample to core
dfr_q_data  out  16  Q sample to core
dfr_returndata  in  26  core result
out_ram_wen  out  1  output RAM write enable
out_ram_addr  out  ADDR_W  output RAM address
out_ram_wdata  out  32  result, sign-extended from 26 bits
sched_busy  out  1  high in any state except IDLE
sched_done  out  1  one-cycle pulse on batch completion
sched_count  out  ADDR_W+1  results written in current/last batch
sched_error  out  1  sticky timeout flag, cleared by cfg_start

Behaviour:
- Reset: state IDLE; every output 0 except dfr_resetn=1; sample index and sched_count 0.
- IDLE: cfg_start with num=0 -> sched_done pulses next cycle, count=0, stay IDLE. cfg_start with num>0 -> latch num, clear count/index/sched_error, go CORE_RST.
- CORE_RST: dfr_resetn=0 for exactly RST_CYCLES cycles, then FETCH.
- FETCH: drive in_ram_addr=index; next state WAIT_RD.
- WAIT_RD: register rdata[15:0]->dfr_i_data, rdata[31:16]->dfr_q_data; go LAUNCH. I/Q held stable until next WAIT_RD.
- LAUNCH: if dfr_busy=0, assert dfr_start for one cycle, go WAIT_DONE; if dfr_busy=1, hold, no start.
- WAIT_DONE: on dfr_done capture dfr_returndata, go WRITE. dfr_done coincident with dfr_start cycle is ignored.
- WRITE: out_ram_wen=1 for one cycle, out_ram_addr=index, wdata={6{r[25]},r}; count and index increment; if new count==num go FINISH else FETCH.
- FINISH: sched_done=1 one cycle, go IDLE.
- Per-sample latency outside the core: 5 cycles (FETCH, WAIT_RD, LAUNCH, WRITE, plus capture cycle).
- cfg_abort: any non-IDLE state -> IDLE next cycle; dfr_resetn driven low that cycle; no sched_done; sched_count keeps value reached. Abort beats simultaneous cfg_start.
- cfg_start while busy: ignored.
- num = 2^ADDR_W: index wraps to 0 only after final write; no extra write.
- Async reset mid-batch: immediate return to reset values; no partial-cycle write.

Optional Feature:
DFR_SCHED_TIMEOUT_EN. Defined: counter runs in LAUNCH and WAIT_DONE, cleared on entry to each; reaching TIMEOUT_CYCLES sets sched_error, behaves as cfg_abort, then asserts sched_done one cycle so host sees termination. Undefined: no counter, sched_error tied 0, scheduler waits indefinitely.

Test Plan:
- num=3, RAM={0x0002_0001,0x0003_0002,0x0005_0004}, core model done 10 cycles after start returning 0x3FFFFFF,5,0x2000000 -> out RAM {0xFFFFFFFF,0x00000005,0xFE000000}, one sched_done, count=3.
- cfg_start num=0 -> sched_done pulse next cycle, no dfr_start, no out_ram_wen, dfr_resetn stays 1.
- dfr_busy held high 20 cycles at LAUNCH -> dfr_start first asserted cycle after busy falls; exactly one start per sample.
- num=8, cfg_abort during 4th WAIT_DONE -> IDLE next cycle, dfr_resetn low one cycle, count=3, no sched_done; subsequent num=2 batch completes normally.
- With DFR_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never asserts done -> sched_error=1 and sched_done at cycle 16 after start; count=0.
- resetn low during WRITE of sample 1 of 4 -> all outputs at reset values immediately, no write issued, sched_busy=0.
